// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial bit-pattern generator with repeat count and abort
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BCW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(PAT_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [PAT_W-1:0] hold_q, hold_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            hold_q    <= '0;
            bit_cnt_q <= '0;
            reps_q    <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            bit_cnt_q <= bit_cnt_d;
            reps_q    <= reps_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs are computed for the cycle after the edge; bit_cnt_q indexes the bit now on dout.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        hold_d    = hold_q;
        bit_cnt_d = bit_cnt_q;
        reps_d    = reps_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort && (reps != '0)) begin
                    state_d   = SHIFT;
                    hold_d    = pattern;
                    shift_d   = pattern << 1;
                    bit_cnt_d = '0;
                    reps_d    = reps;
                    dout_d    = pattern[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    reps_d    = '0;
                end else if (bit_cnt_q == BIT_LAST) begin
                    if (reps_q > CNT_W'(1)) begin
                        reps_d    = reps_q - CNT_W'(1);
                        bit_cnt_d = '0;
                        shift_d   = hold_q << 1;
                        dout_d    = hold_q[PAT_W-1];
                        valid_d   = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                        reps_d    = '0;
                        done_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    shift_d   = shift_q << 1;
                    dout_d    = shift_q[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
